muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 193 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M/RV32M multiply/divide unit.
// Multiplies run shift-add MSB-first into a 2N-bit product. Divides run
// restoring shift-subtract. Both retire one operand bit per CALC cycle.
// Operands are converted to magnitudes up front. Signs are reapplied in FIXUP.
module muldiv_unit #(
  parameter int XLEN = 64
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PREP  = 3'd1;
  localparam logic [2:0] S_CALC  = 3'd2;
  localparam logic [2:0] S_FIXUP = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef struct packed {
    logic [2:0]      op;
    logic            word;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } req_t;

  req_t              req;
  logic [2:0]        state;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   ma, mb, quo, rem;
  logic [2*XLEN-1:0] prod;
  logic              neg_q, neg_r;

  // Operand decode. It is only meaningful while in PREP.
  logic            wm, a_sgn, b_sgn, neg_a, neg_b;
  logic            div0, ovf, min_a, ones_b;
  logic [XLEN-1:0] a_sx, a_zx, b_sx, b_zx, va, vb, mag_a, mag_b;
  logic [XLEN-1:0] fix_v, fix_sx, fix_out;

  // The W-form sign extension only exists when XLEN is wider than the word.
  if (XLEN > 32) begin : g_ext
    assign a_sx   = {{(XLEN-32){req.a[31]}}, req.a[31:0]};
    assign a_zx   = {{(XLEN-32){1'b0}}, req.a[31:0]};
    assign b_sx   = {{(XLEN-32){req.b[31]}}, req.b[31:0]};
    assign b_zx   = {{(XLEN-32){1'b0}}, req.b[31:0]};
    assign fix_sx = {{(XLEN-32){fix_v[31]}}, fix_v[31:0]};
  end else begin : g_noext
    assign a_sx   = req.a;
    assign a_zx   = req.a;
    assign b_sx   = req.b;
    assign b_zx   = req.b;
    assign fix_sx = fix_v;
  end

  assign wm = (XLEN == 32) || req.word;

  // Select which operands are treated as signed for each funct3.
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (req.op)
      OP_MULH, OP_DIV, OP_REM: begin a_sgn = 1'b1; b_sgn = 1'b1; end
      OP_MULHSU:               a_sgn = 1'b1;
      default: ;
    endcase
  end

  assign va     = wm ? (a_sgn ? a_sx : a_zx) : req.a;
  assign vb     = wm ? (b_sgn ? b_sx : b_zx) : req.b;
  assign neg_a  = a_sgn & (wm ? req.a[31] : req.a[XLEN-1]);
  assign neg_b  = b_sgn & (wm ? req.b[31] : req.b[XLEN-1]);
  assign mag_a  = neg_a ? -va : va;
  assign mag_b  = neg_b ? -vb : vb;
  assign div0   = req.op[2] & (wm ? (req.b[31:0] == 32'd0) : (req.b == '0));
  assign min_a  = wm ? (req.a[31:0] == 32'h8000_0000) : (req.a == {1'b1, {(XLEN-1){1'b0}}});
  assign ones_b = wm ? (req.b[31:0] == 32'hFFFF_FFFF) : (req.b == '1);
  assign ovf    = ((req.op == OP_DIV) || (req.op == OP_REM)) & min_a & ones_b;

  // One iteration step for each algorithm. Bit cnt of the scanned operand is consumed MSB first.
  logic [XLEN:0]     r_sh;
  logic              ge;
  logic [XLEN-1:0]   rem_nx;
  logic [2*XLEN-1:0] prod_nx;

  assign r_sh    = {rem, ma[cnt]};
  assign ge      = r_sh >= {1'b0, mb};
  assign rem_nx  = ge ? (r_sh[XLEN-1:0] - mb) : r_sh[XLEN-1:0];
  assign prod_nx = (prod << 1) + (mb[cnt] ? {{XLEN{1'b0}}, ma} : '0);

  // Sign correction and output slice select. W-forms are sign-extended from bit 31.
  logic [2*XLEN-1:0] prod_s;
  always_comb begin
    prod_s = neg_q ? -prod : prod;
    case (req.op)
      OP_MUL:                      fix_v = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_v = wm ? XLEN'(prod_s[63:32]) : prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             fix_v = neg_q ? -quo : quo;
      default:                     fix_v = neg_r ? -rem : rem;
    endcase
  end

  assign fix_out = wm ? fix_sx : fix_v;

  // Control FSM and datapath registers.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state  <= S_IDLE;
      req    <= '0;
      cnt    <= '0;
      ma     <= '0;
      mb     <= '0;
      quo    <= '0;
      rem    <= '0;
      prod   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            req   <= {op, word, a, b};
            state <= S_PREP;
          end else begin
            state <= S_IDLE;
          end
        end
        S_PREP: begin
          ma   <= mag_a;
          mb   <= mag_b;
          prod <= '0;
          if (div0) begin
            // Divide by zero: the quotient is all ones and the remainder is the dividend.
            quo   <= '1;
            rem   <= va;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            state <= S_FIXUP;
          end else if (ovf) begin
            // Signed overflow: the quotient is the dividend and the remainder is zero.
            quo   <= va;
            rem   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            state <= S_FIXUP;
          end else begin
            quo   <= '0;
            rem   <= '0;
            neg_q <= neg_a ^ neg_b;
            neg_r <= neg_a;
            cnt   <= wm ? CW'(31) : CW'(XLEN-1);
            state <= S_CALC;
          end
        end
        S_CALC: begin
          if (req.op[2]) begin
            rem <= rem_nx;
            quo <= {quo[XLEN-2:0], ge};
          end else begin
            prod <= prod_nx;
          end
          if (cnt == '0) state <= S_FIXUP;
          else           cnt   <= cnt - 1'b1;
        end
        S_FIXUP: begin
          result <= fix_out;
          state  <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_PREP) || (state == S_CALC) || (state == S_FIXUP);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed corner cases plus random ops, checked against
// plain SV signed/unsigned arithmetic.
module tb_muldiv_unit;
  localparam int XLEN = 64;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic        word = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        busy, done;
  logic [63:0] result;

  int n_chk = 0;
  int n_pass = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op), .word(word),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference result computed with native 64/128-bit arithmetic.
  function automatic logic [63:0] ref_res(input logic [2:0] o, input logic w,
                                          input logic [63:0] x, input logic [63:0] y);
    longint sa, sb;
    logic [63:0] ua, ub, r;
    logic signed [127:0] pa, pb, p;
    logic zero, ov;
    if (w) begin
      sa = {{32{x[31]}}, x[31:0]};
      sb = {{32{y[31]}}, y[31:0]};
      ua = {32'd0, x[31:0]};
      ub = {32'd0, y[31:0]};
    end else begin
      sa = x; sb = y; ua = x; ub = y;
    end
    zero = (ub == 64'd0);
    ov   = (sa == (w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) && (sb == -64'sd1);
    pa = '0; pb = '0;
    case (o)
      3'd1: begin pa = sa; pb = sb; end
      3'd2: begin pa = sa; pb = {64'd0, ub}; end
      3'd3: begin pa = {64'd0, ua}; pb = {64'd0, ub}; end
      default: ;
    endcase
    p = pa * pb;
    case (o)
      3'd0: r = ua * ub;
      3'd1, 3'd2, 3'd3: r = w ? {32'd0, p[63:32]} : p[127:64];
      3'd4: if (zero) r = '1; else if (ov) r = sa; else r = sa / sb;
      3'd5: if (zero) r = '1; else r = ua / ub;
      3'd6: if (zero) r = sa; else if (ov) r = '0; else r = sa % sb;
      default: if (zero) r = ua; else r = ua % ub;
    endcase
    if (w) r = {{32{r[31]}}, r[31:0]};
    return r;
  endfunction

  // Cycles from the start edge to done: the short path for div-by-zero or overflow, else N+3.
  function automatic int ref_lat(input logic [2:0] o, input logic w,
                                 input logic [63:0] x, input logic [63:0] y);
    logic bz, ov;
    bz = w ? (y[31:0] == 32'd0) : (y == 64'd0);
    ov = w ? (x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF)
           : (x == 64'h8000_0000_0000_0000 && y == '1);
    if (o[2] && (bz || (!o[0] && ov))) return 3;
    return w ? 35 : 67;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_8000_0000;
      4: return 64'($urandom_range(0, 20));
      5: return -64'($urandom_range(1, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Present a request for one edge, then scramble the inputs to prove they were latched.
  task automatic start_op(input logic [2:0] o, input logic w, input logic [63:0] x, input logic [63:0] y);
    op = o; word = w; a = x; b = y; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    op = 3'($urandom); word = 1'($urandom); a = {$urandom, $urandom}; b = {$urandom, $urandom};
  endtask

  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    for (int i = 0; i < 200; i++) begin
      @(posedge CLK); #1;
      lat++;
      if (done) break;
    end
    chk("done_seen", done, 1'b1);
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic w,
                     input logic [63:0] x, input logic [63:0] y,
                     input logic [63:0] exp, input int exp_lat, input bit b2b);
    int lat;
    start_op(o, w, x, y);
    chk({tag, "_busy"}, busy, 1'b1);
    wait_done(1, lat);
    chk({tag, "_res"}, result, exp);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    if (!b2b) begin
      @(posedge CLK); #1;
      chk({tag, "_pulse"}, {62'd0, busy, done}, 64'd0);
      chk({tag, "_hold"}, result, exp);
    end
  endtask

  initial begin
    int lat;
    logic [2:0] ro;
    logic rw;
    logic [63:0] rx, ry, exp;

    // Reset with start held high must stay idle.
    op = 3'd0; a = 64'd1; b = 64'd1; start = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 64'd0);
    RST = 1'b1;

    run("mul_neg",  3'd0, 1'b0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 67, 1'b0);
    run("mulhu",    3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 67, 1'b0);
    run("mulhsu",   3'd2, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 67, 1'b0);
    run("div0",     3'd4, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 3, 1'b0);
    run("rem0",     3'd6, 1'b0, 64'd5, 64'd0, 64'd5, 3, 1'b0);
    run("div_ovf",  3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 3, 1'b0);
    run("rem_ovf",  3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 3, 1'b0);
    run("divw",     3'd4, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 35, 1'b0);
    run("remuw",    3'd7, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h10, 64'hF, 35, 1'b0);
    run("div_neg",  3'd4, 1'b0, -64'sd7, 64'd2, -64'sd3, 67, 1'b0);
    run("rem_neg",  3'd6, 1'b0, -64'sd7, 64'd2, -64'sd1, 67, 1'b0);

    // Back-to-back: the second start lands in the DONE cycle of the first.
    run("b2b_a",    3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 67, 1'b1);
    run("b2b_b",    3'd0, 1'b0, 64'd6, 64'd7, 64'd42, 67, 1'b0);

    // A start pulse mid-CALC must not disturb the running divide.
    exp = ref_res(3'd4, 1'b0, 64'd1000003, -64'sd97);
    start_op(3'd4, 1'b0, 64'd1000003, -64'sd97);
    repeat (10) @(posedge CLK);
    #1;
    op = 3'd0; a = 64'd123; b = 64'd456; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    wait_done(12, lat);
    chk("glitch_res", result, exp);
    chk("glitch_lat", 64'(lat), 64'd67);
    @(posedge CLK); #1;

    // Random ops with corner-biased operands, mixing idle gaps and back-to-back issue.
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      rw = 1'($urandom_range(0, 1));
      rx = pick();
      ry = pick();
      run($sformatf("rnd%0d", i), ro, rw, rx, ry, ref_res(ro, rw, rx, ry),
          ref_lat(ro, rw, rx, ry), 1'($urandom_range(0, 1)));
    end

    // Reset at start+20 of a DIVU aborts it and clears the outputs.
    start_op(3'd5, 1'b0, {$urandom, $urandom}, 64'd3);
    repeat (19) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_result", result, 64'd0);
    RST = 1'b1;
    run("mul34", 3'd0, 1'b0, 64'd3, 64'd4, 64'd12, 67, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
